layer_compositor: RTL and testbench

Parametrised successor to the top-level grey/white colour-select logic. Merges LAYERS prioritised sprite/background hit streams into one RGB332 pixel through a 2-stage pipeline, using a 4-entry frame-synchronous palette. Adds night-mode inversion and a game-over flash. Sits between the delegate modules (TRex, obstacles, background, scoreboard) and the VGA colour pins; runs on the pixel clock domain.

---
 rtl/layer_compositor_pkg.sv | 36 +++
 rtl/layer_compositor_flash_timer.sv | 47 ++++
 rtl/layer_compositor.sv | 106 ++++++++++
 tb/tb_layer_compositor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared game definitions: game-state encodings, RGB332 layout, reset palette
// and the active screen size.
package layer_compositor_pkg;

  typedef enum logic [1:0] {
    GS_INIT = 2'b00,
    GS_PLAY = 2'b01,
    GS_DEAD = 2'b10
  } gameState_t;

  localparam int unsigned RED_W       = 3;
  localparam int unsigned GREEN_W     = 3;
  localparam int unsigned BLUE_W      = 2;
  localparam int unsigned RGB_W       = RED_W + GREEN_W + BLUE_W;
  localparam int unsigned PAL_ENTRIES = 4;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [RGB_W-1:0] PAL_DEF0 = 8'hFF;
  localparam logic [RGB_W-1:0] PAL_DEF1 = 8'h00;
  localparam logic [RGB_W-1:0] PAL_DEF2 = 8'hFF;
  localparam logic [RGB_W-1:0] PAL_DEF3 = 8'hE0;

  function automatic logic [RGB_W-1:0] palDefault(input logic [1:0] idx);
    logic [RGB_W-1:0] val;
    case (idx)
      2'd0:    val = PAL_DEF0;
      2'd1:    val = PAL_DEF1;
      2'd2:    val = PAL_DEF2;
      default: val = PAL_DEF3;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/layer_compositor_flash_timer.sv
// Game-over flash: counts frames while dead and toggles the flash phase
// every FLASH_FRAMES frames; any non-dead state clears it at once.
module flash_timer
  import layer_compositor_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frameStart,
  input  logic [1:0] gameState,
  output logic       flashPhase
);

  typedef enum logic {IDLE, FLASH} flashState_t;

  flashState_t state;
  logic [7:0]  flashCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      flashCnt   <= '0;
      flashPhase <= 1'b0;
    end else if (gameState != GS_DEAD) begin
      state      <= IDLE;
      flashCnt   <= '0;
      flashPhase <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FLASH;
        FLASH: begin
          if (frameStart) begin
            if (flashCnt == 8'(FLASH_FRAMES - 1)) begin
              flashCnt   <= '0;
              flashPhase <= ~flashPhase;
            end else begin
              flashCnt <= flashCnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Priority-merges LAYERS colour-index streams into one RGB332 pixel through a
// 2-stage pix_en pipeline with a frame-synchronous double-buffered palette.
module layer_compositor #(
  parameter int unsigned LAYERS       = 4,
  parameter int unsigned SCREEN_W     = layer_compositor_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H     = layer_compositor_pkg::SCREEN_H,
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_en,
  input  logic                frame_start,
  input  logic [9:0]          vga_x,
  input  logic [8:0]          vga_y,
  input  logic [2*LAYERS-1:0] layer_idx,
  input  logic [1:0]          game_state,
  input  logic                night_mode,
  input  logic                pal_we,
  input  logic [1:0]          pal_addr,
  input  logic [7:0]          pal_data,
  output logic [2:0]          vga_red,
  output logic [2:0]          vga_green,
  output logic [1:0]          vga_blue,
  output logic                pix_valid
);
  import layer_compositor_pkg::*;

  logic [RGB_W-1:0] activePal [PAL_ENTRIES];
  logic [RGB_W-1:0] shadowPal [PAL_ENTRIES];
  logic             commitPending;
  logic             nightLat;
  logic             flashPhase;
  logic             invert;

  logic [1:0]       selIdxNext, selIdx;
  logic             visNext, vis;
  logic             found;
  logic [RGB_W-1:0] rgb;

  always_comb begin
    selIdxNext = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (!found && layer_idx[2*i +: 2] != '0) begin
        selIdxNext = layer_idx[2*i +: 2];
        found      = 1'b1;
      end
    end
    visNext = (vga_x != '0) && (vga_x <= 10'(SCREEN_W)) &&
              (vga_y != '0) && (vga_y <= 9'(SCREEN_H));
  end

  // A write coinciding with a commit lands only in the shadow copy: the commit
  // reads the pre-write shadow, and the later pending-set keeps it queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PAL_ENTRIES; i++) begin
        activePal[i] <= palDefault(2'(i));
        shadowPal[i] <= palDefault(2'(i));
      end
      commitPending <= 1'b0;
      nightLat      <= 1'b0;
    end else begin
      if (frame_start) begin
        nightLat <= night_mode;
        if (commitPending) begin
          for (int unsigned i = 0; i < PAL_ENTRIES; i++) activePal[i] <= shadowPal[i];
          commitPending <= 1'b0;
        end
      end
      if (pal_we) begin
        shadowPal[pal_addr] <= pal_data;
        commitPending       <= 1'b1;
      end
    end
  end

  flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) uFlash (
    .clk        (clk),
    .rst        (rst),
    .frameStart (frame_start),
    .gameState  (game_state),
    .flashPhase (flashPhase)
  );

  assign invert = nightLat ^ flashPhase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      selIdx    <= '0;
      vis       <= 1'b0;
      rgb       <= '0;
      pix_valid <= 1'b0;
    end else if (pix_en) begin
      selIdx    <= selIdxNext;
      vis       <= visNext;
      pix_valid <= vis;
      rgb       <= vis ? (activePal[selIdx] ^ {RGB_W{invert}}) : '0;
    end
  end

  assign vga_red   = rgb[RGB_W-1 -: RED_W];
  assign vga_green = rgb[BLUE_W +: GREEN_W];
  assign vga_blue  = rgb[BLUE_W-1:0];

endmodule

// File: tb/tb_layer_compositor.sv
// Directed-plus-random bench for layer_compositor against a frame-level model
// of palette commits, night latch and flash phase.
module tb_layer_compositor;

  localparam int FLASHN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] vga_x = '0;
  logic [8:0] vga_y = '0;
  logic [7:0] layer_idx = '0;
  logic [1:0] game_state = '0;
  logic       night_mode = 1'b0;
  logic       pal_we = 1'b0;
  logic [1:0] pal_addr = '0;
  logic [7:0] pal_data = '0;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;
  logic       pix_valid;

  layer_compositor #(.LAYERS(4), .FLASH_FRAMES(FLASHN)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .frame_start(frame_start),
    .vga_x(vga_x), .vga_y(vga_y), .layer_idx(layer_idx), .game_state(game_state),
    .night_mode(night_mode), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] mAct [4];
  logic [7:0] mShd [4];
  bit         mPend, mNight, mDead;
  int         mFrames;
  logic [7:0] pLayers;
  logic [9:0] pX;
  logic [8:0] pY;
  int         asserts = 0;
  int         failures = 0;

  function automatic logic [8:0] expPix(logic [7:0] lay, logic [9:0] x, logic [8:0] y);
    int idx = 0;
    bit vis, inv;
    for (int k = 3; k >= 0; k--)
      if (lay[2*k +: 2] != 2'd0) idx = int'(lay[2*k +: 2]);
    vis = (x >= 1) && (x <= 640) && (y >= 1) && (y <= 480);
    inv = mNight ^ (mDead && ((mFrames / FLASHN) % 2 == 1));
    return vis ? {1'b1, mAct[idx] ^ {8{inv}}} : 9'h000;
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {pix_valid, vga_red, vga_green, vga_blue};
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset;
    mAct = '{8'hFF, 8'h00, 8'hFF, 8'hE0};
    mShd = '{8'hFF, 8'h00, 8'hFF, 8'hE0};
    mPend = 0; mNight = 0; mFrames = 0;
    pLayers = '0; pX = '0; pY = '0;
  endtask

  // One pix_en strobe every 4 clocks; output reflects the previous strobe's pixel.
  task automatic step(input string tag, input logic [7:0] lay, input logic [9:0] x,
                      input logic [8:0] y);
    logic [8:0] e;
    layer_idx = lay; vga_x = x; vga_y = y;
    pix_en = 1'b1;
    tick;
    pix_en = 1'b0;
    e = expPix(pLayers, pX, pY);
    check(tag, e);
    pLayers = lay; pX = x; pY = y;
    tick; tick; tick;
    check({tag, "_hold"}, e);
  endtask

  task automatic frameStart(input bit we, input logic [1:0] a, input logic [7:0] d);
    frame_start = 1'b1; pal_we = we; pal_addr = a; pal_data = d;
    tick;
    frame_start = 1'b0; pal_we = 1'b0;
    mNight = night_mode;
    if (mDead) mFrames++;
    if (mPend) begin
      for (int i = 0; i < 4; i++) mAct[i] = mShd[i];
      mPend = 0;
    end
    if (we) begin mShd[a] = d; mPend = 1; end
  endtask

  task automatic palWrite(input logic [1:0] a, input logic [7:0] d);
    pal_we = 1'b1; pal_addr = a; pal_data = d;
    tick;
    pal_we = 1'b0;
    mShd[a] = d; mPend = 1;
  endtask

  task automatic setState(input logic [1:0] gs);
    game_state = gs;
    tick;
    mDead = (gs == 2'b10);
    if (!mDead) mFrames = 0;
  endtask

  logic [9:0] bx [7] = '{10'd640, 10'd641, 10'd640, 10'd1, 10'd0, 10'd1, 10'd1023};
  logic [8:0] by [7] = '{9'd480, 9'd480, 9'd481, 9'd1, 9'd1, 9'd0, 9'd511};

  initial begin
    modelReset();
    mDead = 0;
    tick; tick;
    check("reset", 9'h000);
    rst = 1'b1;
    tick;

    step("first", 8'h00, 10'd100, 9'd100);
    step("bg_on", 8'h00, 10'd0, 9'd100);
    step("bg_off", 8'h00, 10'd100, 9'd100);
    for (int i = 0; i < 7; i++) step("bound", 8'($urandom), bx[i], by[i]);
    step("bound_last", 8'h00, 10'd50, 9'd50);

    step("prio_a", 8'b11_00_01_00, 10'd200, 9'd200);
    step("prio_b", 8'b11_00_01_11, 10'd200, 9'd200);
    step("prio_c", 8'b11_00_01_11, 10'd200, 9'd200);

    palWrite(2'd1, 8'h1C);
    step("pal_pend", 8'b00_00_01_00, 10'd10, 9'd10);
    step("pal_pend2", 8'b00_00_01_00, 10'd10, 9'd10);
    frameStart(1'b0, 2'd0, 8'h00);
    step("pal_commit", 8'b00_00_01_00, 10'd10, 9'd10);

    palWrite(2'd2, 8'h12);
    frameStart(1'b1, 2'd2, 8'h34);
    step("coin_a", 8'b00_10_00_00, 10'd20, 9'd20);
    step("coin_b", 8'b00_10_00_00, 10'd20, 9'd20);
    frameStart(1'b0, 2'd0, 8'h00);
    step("coin_c", 8'b00_10_00_00, 10'd20, 9'd20);

    night_mode = 1'b1;
    step("night_pend", 8'h00, 10'd30, 9'd30);
    step("night_pend2", 8'b11_00_00_00, 10'd30, 9'd30);
    frameStart(1'b0, 2'd0, 8'h00);
    step("night_bg", 8'h00, 10'd30, 9'd30);
    step("night_e3", 8'h00, 10'd700, 9'd30);
    step("night_off", 8'b11_00_00_00, 10'd30, 9'd30);
    step("night_e3b", 8'h00, 10'd30, 9'd30);

    night_mode = 1'b0;
    frameStart(1'b0, 2'd0, 8'h00);
    setState(2'b10);
    for (int f = 0; f < 7; f++) begin
      frameStart(1'b0, 2'd0, 8'h00);
      step("flash", 8'h00, 10'd40, 9'd40);
    end
    setState(2'b00);
    step("flash_exit", 8'h00, 10'd40, 9'd40);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 15))
        0, 1:    frameStart(1'($urandom), 2'($urandom), 8'($urandom));
        2, 3:    palWrite(2'($urandom), 8'($urandom));
        4:       night_mode = ~night_mode;
        5:       setState(2'($urandom));
        default: step("rand", 8'($urandom), 10'($urandom_range(0, 700)),
                      9'($urandom_range(0, 500)));
      endcase
    end

    setState(2'b00);
    night_mode = 1'b1;
    frameStart(1'b0, 2'd0, 8'h00);
    step("pre_rst", 8'h00, 10'd100, 9'd100);
    step("pre_rst2", 8'h00, 10'd100, 9'd100);
    #2 rst = 1'b0;
    #1 check("rst_async", 9'h000);
    modelReset();
    tick;
    rst = 1'b1;
    tick;
    step("post_rst1", 8'h00, 10'd100, 9'd100);
    step("post_rst2", 8'h00, 10'd100, 9'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
